eth_wb_arbiter: RTL and testbench
=================================

Name: eth_wb_arbiter

Overview:
Two-master to one-slave WISHBONE arbiter. It shares the system memory bus between the Ethernet MAC DMA master (port 0) and the CPU data master (port 1).
- Round-robin grant, locked for the duration of a bus cycle (cyc held).
- Bus watchdog: a stalled slave access is terminated with an error to the granted master.
- Sits between the MAC master interface and the memory-side interconnect.

Parameters:
AW, 32, address width
DW, 32, data width (sel width = DW/8)
TIMEOUT, 255, slave cycles allowed per strobe before forced error (1..65535)
TW, 16, watchdog counter width

Ports:
wb_clk_i  in  1  WISHBONE clock, single clock domain
wb_rst_i  in  1  synchronous reset, active-high
mN_adr_i  in  AW  master N address (N=0 MAC DMA, N=1 CPU)
mN_dat_i  in  DW  master N write data
mN_sel_i  in  DW/8  master N byte selects
mN_we_i  in  1  master N write enable
mN_cyc_i  in  1  master N cycle request
mN_stb_i  in  1  master N strobe
mN_dat_o  out  DW  read data to master N
mN_ack_o  out  1  acknowledge to master N
mN_err_o  out  1  error to master N
s_adr_o  out  AW  slave address
s_dat_o  out  DW  slave write data
s_sel_o  out  DW/8  slave byte selects
s_we_o  out  1  slave write enable
s_cyc_o  out  1  slave cycle
s_stb_o  out  1  slave strobe
s_dat_i  in  DW  slave read data
s_ack_i  in  1  slave acknowledge
s_err_i  in  1  slave error
gnt_o  out  2  one-hot current grant (bit N = master N), 00 when idle
timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
Reset (synchronous, wb_rst_i high at a wb_clk_i edge):
- State IDLE, last_gnt=1 (master 0 wins the first contention), watchdog=0.
- All outputs 0, except mN_dat_o, which follows s_dat_i.
- Reset mid-transfer drops s_cyc_o/s_stb_o on the next edge. No ack or err is delivered to the master.

State machine (registered): IDLE, GNT0, GNT1.
- IDLE -> GNTk if only mk_cyc_i is high.
- IDLE with both requesting -> GNT(not last_gnt).
- GNTk stays while mk_cyc_i=1.
- When mk_cyc_i=0:
  - go to GNTj if the other master j has cyc high (direct handover, no idle cycle);
  - otherwise go to IDLE.
  - last_gnt <= k.
- Arbitration latency: a request in IDLE is granted on the next edge. s_cyc_o rises one cycle after mk_cyc_i.

Datapath (combinational from the registered grant):
- In GNTk: s_adr/dat/sel/we = master k inputs; s_cyc_o = mk_cyc_i; s_stb_o = mk_stb_i.
- mk_ack_o = s_ack_i; mk_err_o = s_err_i | wd_err.
- The non-granted master sees ack=0 and err=0.
- In IDLE: s_cyc_o = s_stb_o = 0.
- mN_dat_o = s_dat_i for both masters, qualified by ack only.

Bursts and locking:
- The grant never changes while the granted cyc is high, even with stb low between beats.
- A master holding cyc indefinitely starves the other; this is by design for atomic sequences.

Watchdog:
- Counter increments each cycle s_cyc_o & s_stb_o & !s_ack_i & !s_err_i.
- Clears on ack, err, stb low, or grant change.
- When count == TIMEOUT-1 and still no response:
  - wd_err=1 for exactly one cycle (the granted mk_err_o pulses);
  - timeout_o pulses;
  - counter clears.
- If the slave acks in the same cycle the watchdog would fire, the ack wins and no error is raised.

Simultaneous events:
- Granted master drops cyc in the same cycle the other raises it: handover on the next edge.
- Both masters drop cyc: IDLE.
- s_ack_i while s_stb_o=0 is ignored; it still routes to the granted ack.

Test Plan:
- Reset, then m0 and m1 raise cyc/stb together on cycle 0 -> gnt_o=01 at cycle 1. m1 is granted after m0 drops cyc (gnt_o=10 the next cycle, no IDLE gap). Next contention grants m0.
- m1 holds cyc across 4 stb beats with stb low between them while m0 requests -> gnt_o stays 10 for all beats. m1_ack_o mirrors s_ack_i. m0_ack_o stays 0.
- m0 write adr=0x0000_1000, dat=0xDEADBEEF, sel=0xF -> s_adr_o/s_dat_o/s_sel_o/s_we_o match one cycle after cyc. Ack after 3 wait states is passed through.
- TIMEOUT=8, slave never acks -> m0_err_o and timeout_o pulse exactly once, 8 cycles after s_stb_o rises. The counter restarts if stb stays high.
- TIMEOUT=8, slave acks on the 8th cycle -> ack is delivered, err stays 0, timeout_o stays 0.
- wb_rst_i asserted mid-transfer in GNT1 -> next cycle gnt_o=00, s_cyc_o=0, no ack or err. After release, the first contention grants m0.

Source files
------------

// File: rtl/eth_wb_arbiter.sv
// Purpose : two-master (0 = MAC DMA, 1 = CPU) to one-slave WISHBONE arbiter with round-robin grant and bus watchdog.
// Latency : a request in IDLE is granted on the next edge; the slave bus then follows the granted master combinationally.
// Backpres: the grant is held while the granted cyc is high; a slave stalled for TIMEOUT strobe cycles is errored out.
//
// Ports:
//   wb_clk_i / wb_rst_i          clock, synchronous active-high reset
//   mN_*_i / mN_*_o (N = 0, 1)   master-side WISHBONE (adr, dat, sel, we, cyc, stb / dat, ack, err)
//   s_*_o / s_*_i                slave-side WISHBONE
//   gnt_o                        one-hot current grant, 00 when idle
//   timeout_o                    one-cycle pulse when the watchdog fires
module eth_wb_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255,
    parameter int TW      = 16
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    output logic [1:0]      gnt_o,
    output logic            timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    state_t          r_state;
    logic [1:0]      r_gnt;
    logic            r_last_gnt;
    logic [TW-1:0]   r_wd_cnt;

    logic            w_g0;
    logic            w_g1;
    logic            w_stall;
    logic            w_wd_err;

    // Grant FSM. r_last_gnt records the master that most recently released
    // the bus; on contention from IDLE the other master wins.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state    <= ST_IDLE;
            r_gnt      <= 2'b00;
            r_last_gnt <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (m0_cyc_i && m1_cyc_i) begin
                        if (r_last_gnt) begin
                            r_state <= ST_GNT0;
                            r_gnt   <= 2'b01;
                        end else begin
                            r_state <= ST_GNT1;
                            r_gnt   <= 2'b10;
                        end
                    end else if (m0_cyc_i) begin
                        r_state <= ST_GNT0;
                        r_gnt   <= 2'b01;
                    end else if (m1_cyc_i) begin
                        r_state <= ST_GNT1;
                        r_gnt   <= 2'b10;
                    end
                end
                ST_GNT0: begin
                    if (!m0_cyc_i) begin
                        r_last_gnt <= 1'b0;
                        if (m1_cyc_i) begin
                            r_state <= ST_GNT1;
                            r_gnt   <= 2'b10;
                        end else begin
                            r_state <= ST_IDLE;
                            r_gnt   <= 2'b00;
                        end
                    end
                end
                ST_GNT1: begin
                    if (!m1_cyc_i) begin
                        r_last_gnt <= 1'b1;
                        if (m0_cyc_i) begin
                            r_state <= ST_GNT0;
                            r_gnt   <= 2'b01;
                        end else begin
                            r_state <= ST_IDLE;
                            r_gnt   <= 2'b00;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 2'b00;
                end
            endcase
        end
    end

    assign w_g0 = (r_state == ST_GNT0);
    assign w_g1 = (r_state == ST_GNT1);

    // Slave-side mux; everything is zero while idle.
    assign s_adr_o = w_g1 ? m1_adr_i : (w_g0 ? m0_adr_i : '0);
    assign s_dat_o = w_g1 ? m1_dat_i : (w_g0 ? m0_dat_i : '0);
    assign s_sel_o = w_g1 ? m1_sel_i : (w_g0 ? m0_sel_i : '0);
    assign s_we_o  = (w_g0 & m0_we_i)  | (w_g1 & m1_we_i);
    assign s_cyc_o = (w_g0 & m0_cyc_i) | (w_g1 & m1_cyc_i);
    assign s_stb_o = (w_g0 & m0_stb_i) | (w_g1 & m1_stb_i);

    // Watchdog. The fire term is combinational so a slave response in the
    // last allowed cycle masks it (ack wins). A grant change always passes
    // through a cycle with the granted cyc low, which already clears the count.
    assign w_stall  = s_cyc_o & s_stb_o & ~s_ack_i & ~s_err_i;
    assign w_wd_err = w_stall & (r_wd_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wd_cnt <= '0;
        end else if (!w_stall || w_wd_err) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + TW'(1);
        end
    end

    // Master-side returns; read data is shared and qualified by ack alone.
    assign m0_dat_o  = s_dat_i;
    assign m1_dat_o  = s_dat_i;
    assign m0_ack_o  = w_g0 & s_ack_i;
    assign m1_ack_o  = w_g1 & s_ack_i;
    assign m0_err_o  = w_g0 & (s_err_i | w_wd_err);
    assign m1_err_o  = w_g1 & (s_err_i | w_wd_err);
    assign gnt_o     = r_gnt;
    assign timeout_o = w_wd_err;

endmodule

// File: tb/tb_eth_wb_arbiter.sv
// Purpose : self-checking bench for eth_wb_arbiter (TIMEOUT = 8), directed scenarios plus randomized traffic vs a reference model.
// Latency : inputs are driven 1 time unit after the rising edge and outputs are sampled 1 unit later.
// Backpres: none; every scenario runs a fixed number of cycles.
module tb_eth_wb_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_i;
    logic [AW-1:0]   m0_adr_i, m1_adr_i;
    logic [DW-1:0]   m0_dat_i, m1_dat_i;
    logic [DW/8-1:0] m0_sel_i, m1_sel_i;
    logic            m0_we_i, m0_cyc_i, m0_stb_i;
    logic            m1_we_i, m1_cyc_i, m1_stb_i;
    logic [DW-1:0]   m0_dat_o, m1_dat_o;
    logic            m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [DW/8-1:0] s_sel_o;
    logic            s_we_o, s_cyc_o, s_stb_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack_i, s_err_i;
    logic [1:0]      gnt_o;
    logic            timeout_o;

    int n_checks = 0;
    int n_fail   = 0;

    eth_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO), .TW(16)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .s_err_i(s_err_i), .gnt_o(gnt_o), .timeout_o(timeout_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // {gnt[1:0], s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err, timeout}
    function automatic logic [8:0] status();
        return {gnt_o, s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, timeout_o};
    endfunction

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic clear_masters();
        m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_we_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_we_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        s_ack_i = 0; s_err_i = 0;
    endtask

    task automatic test_reset();
        logic [8:0] st;
        wb_rst_i = 1;
        clear_masters();
        s_dat_i = 32'h1234_5678;
        step();
        step();
        s_ack_i = 1;
        #1;
        st = status();
        n_checks++;
        if (st !== 9'd0) begin
            n_fail++; $display("FAIL reset_status: got %b expected %b", st, 9'd0);
        end
        n_checks++;
        if (s_adr_o !== '0 || s_dat_o !== '0 || s_sel_o !== '0 || s_we_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_bus: got adr %h dat %h sel %h we %b expected zeros", s_adr_o, s_dat_o, s_sel_o, s_we_o);
        end
        n_checks++;
        if (m0_dat_o !== 32'h1234_5678 || m1_dat_o !== 32'h1234_5678) begin
            n_fail++; $display("FAIL reset_rdata: got %h/%h expected 12345678", m0_dat_o, m1_dat_o);
        end
        s_ack_i = 0;
    endtask

    task automatic test_contention();
        logic [8:0] st;
        wb_rst_i = 0;
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1; s_ack_i = 0;
        #1; st = status(); n_checks++;
        if (st !== 9'b00_0000000) begin n_fail++; $display("FAIL cont_idle: got %b expected %b", st, 9'b00_0000000); end
        step(); #1; st = status(); n_checks++;
        if (st !== 9'b01_1100000) begin n_fail++; $display("FAIL cont_first_m0: got %b expected %b", st, 9'b01_1100000); end
        m0_cyc_i = 0; m0_stb_i = 0;
        #1; st = status(); n_checks++;
        if (st !== 9'b01_0000000) begin n_fail++; $display("FAIL cont_m0_drop: got %b expected %b", st, 9'b01_0000000); end
        step(); #1; st = status(); n_checks++;
        if (st !== 9'b10_1100000) begin n_fail++; $display("FAIL cont_handover_m1: got %b expected %b", st, 9'b10_1100000); end
        m1_cyc_i = 0; m1_stb_i = 0;
        step(); #1; st = status(); n_checks++;
        if (st !== 9'b00_0000000) begin n_fail++; $display("FAIL cont_back_idle: got %b expected %b", st, 9'b00_0000000); end
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        step(); #1; n_checks++;
        if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL cont_second_m0: got %b expected 01", gnt_o); end
        clear_masters();
        step();
    endtask

    task automatic test_burst_lock();
        logic [8:0] st;
        logic [8:0] ex;
        m1_cyc_i = 1; m1_stb_i = 0;
        step();
        m0_cyc_i = 1; m0_stb_i = 1;
        for (int b = 0; b < 4; b++) begin
            m1_stb_i = 1; s_ack_i = 1;
            #1; st = status(); n_checks++;
            if (st !== 9'b10_1101000) begin n_fail++; $display("FAIL burst_beat%0d: got %b expected %b", b, st, 9'b10_1101000); end
            step();
            // an ack with stb low still routes to the granted master
            m1_stb_i = 0; s_ack_i = (b == 3);
            ex = {2'b10, 1'b1, 1'b0, 1'b0, (b == 3), 3'b000};
            #1; st = status(); n_checks++;
            if (st !== ex) begin n_fail++; $display("FAIL burst_gap%0d: got %b expected %b", b, st, ex); end
            step();
        end
        s_ack_i = 0; m1_cyc_i = 0;
        step(); #1; st = status(); n_checks++;
        if (st !== 9'b01_1100000) begin n_fail++; $display("FAIL burst_handover: got %b expected %b", st, 9'b01_1100000); end
        clear_masters();
        step();
    endtask

    task automatic test_write_passthrough();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1;
        m0_adr_i = 32'h0000_1000; m0_dat_i = 32'hDEAD_BEEF; m0_sel_i = 4'hF;
        #1; n_checks++;
        if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL wr_not_yet: got s_cyc %b expected 0", s_cyc_o); end
        step(); #1; n_checks++;
        if ({s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o} !== {32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 3'b111}) begin
            n_fail++; $display("FAIL wr_bus: got %h %h %h %b%b%b expected 00001000 deadbeef f 111",
                               s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o);
        end
        for (int w = 0; w < 3; w++) begin
            #1; n_checks++;
            if (m0_ack_o !== 1'b0) begin n_fail++; $display("FAIL wr_wait%0d: got ack %b expected 0", w, m0_ack_o); end
            step();
        end
        s_ack_i = 1; s_dat_i = 32'hCAFE_F00D;
        #1; n_checks++;
        if ({m0_ack_o, m0_err_o, m0_dat_o} !== {2'b10, 32'hCAFE_F00D}) begin
            n_fail++; $display("FAIL wr_ack: got ack %b err %b dat %h expected 1 0 cafef00d", m0_ack_o, m0_err_o, m0_dat_o);
        end
        step();
        clear_masters();
        step();
    endtask

    task automatic test_timeout();
        logic ex;
        int pulses = 0;
        m0_cyc_i = 1; m0_stb_i = 1;
        step();
        for (int i = 0; i < 16; i++) begin
            ex = (i == TO - 1) || (i == 2 * TO - 1);
            #1; n_checks++;
            if ({m0_err_o, timeout_o, m1_err_o, m0_ack_o} !== {ex, ex, 2'b00}) begin
                n_fail++; $display("FAIL timeout_cyc%0d: got err %b to %b m1err %b ack %b expected %b %b 0 0",
                                   i, m0_err_o, timeout_o, m1_err_o, m0_ack_o, ex, ex);
            end
            if (i < TO && timeout_o === 1'b1) pulses++;
            step();
        end
        n_checks++;
        if (pulses !== 1) begin n_fail++; $display("FAIL timeout_once: got %0d pulses expected 1", pulses); end
        clear_masters();
        step();
    endtask

    task automatic test_ack_at_limit();
        m0_cyc_i = 1; m0_stb_i = 1;
        step();
        for (int i = 0; i < TO; i++) begin
            s_ack_i = (i == TO - 1);
            #1; n_checks++;
            if ({m0_ack_o, m0_err_o, timeout_o} !== {(i == TO - 1), 2'b00}) begin
                n_fail++; $display("FAIL ack_limit_cyc%0d: got ack %b err %b to %b expected %b 0 0",
                                   i, m0_ack_o, m0_err_o, timeout_o, (i == TO - 1));
            end
            step();
        end
        clear_masters();
        step();
    endtask

    task automatic test_reset_mid();
        logic [8:0] st;
        m1_cyc_i = 1; m1_stb_i = 1;
        step(); #1; n_checks++;
        if (gnt_o !== 2'b10) begin n_fail++; $display("FAIL rstmid_gnt1: got %b expected 10", gnt_o); end
        wb_rst_i = 1; m0_cyc_i = 1; m0_stb_i = 1;
        step();
        s_ack_i = 1;
        #1; st = status(); n_checks++;
        if (st !== 9'd0) begin n_fail++; $display("FAIL rstmid_drop: got %b expected %b", st, 9'd0); end
        s_ack_i = 0; wb_rst_i = 0;
        step(); #1; n_checks++;
        if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL rstmid_first_m0: got %b expected 01", gnt_o); end
        clear_masters();
        step();
    endtask

    // Reference model: owner is the granted master (-1 when idle), last is the
    // master that most recently released, wd counts consecutive stalled cycles.
    task automatic test_random();
        int owner = -1;
        int last  = 1;
        int wd    = 0;
        logic c[2], s[2];
        logic [AW-1:0] a[2];
        logic ack, err, ecyc, estb, stall, fire;
        logic [8:0] ex, st;
        logic [AW-1:0] eadr;
        wb_rst_i = 1; clear_masters();
        step(); step();
        wb_rst_i = 0;
        c[0] = 0; c[1] = 0;
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 5) == 0) c[k] = ~c[k];
                s[k] = ($urandom_range(0, 3) != 0);
                a[k] = $urandom;
            end
            ack = ($urandom_range(0, 11) == 0);
            err = ($urandom_range(0, 29) == 0);
            m0_cyc_i = c[0]; m0_stb_i = s[0]; m0_adr_i = a[0];
            m1_cyc_i = c[1]; m1_stb_i = s[1]; m1_adr_i = a[1];
            s_ack_i = ack; s_err_i = err; s_dat_i = $urandom;
            ecyc  = (owner >= 0) ? c[owner] : 1'b0;
            estb  = (owner >= 0) ? s[owner] : 1'b0;
            eadr  = (owner >= 0) ? a[owner] : '0;
            stall = ecyc && estb && !ack && !err;
            fire  = stall && (wd == TO - 1);
            ex = {(owner == 1), (owner == 0), ecyc, estb,
                  (owner == 0) && ack, (owner == 1) && ack,
                  (owner == 0) && (err || fire), (owner == 1) && (err || fire), fire};
            #1; st = status(); n_checks++;
            if (st !== ex || s_adr_o !== eadr) begin
                n_fail++; $display("FAIL random_cyc%0d: got %b adr %h expected %b adr %h", n, st, s_adr_o, ex, eadr);
            end
            wd = (stall && !fire) ? wd + 1 : 0;
            if (owner < 0) begin
                if (c[0] && c[1]) owner = 1 - last;
                else if (c[0])    owner = 0;
                else if (c[1])    owner = 1;
            end else if (!c[owner]) begin
                last  = owner;
                owner = c[1 - owner] ? 1 - owner : -1;
            end
            step();
        end
        clear_masters();
        step();
    endtask

    initial begin
        s_dat_i = '0;
        test_reset();
        test_contention();
        test_burst_lock();
        test_write_passthrough();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
